// File: rtl/dds_freq_meter.sv
// Frequency meter: counts input rising edges over a 2^GATE_LOG2-cycle gate and returns the
// matching DDS tuning word. Define FREQ_METER_CONT_EN for free-running continuous measurement.
module dds_freq_meter #(
   parameter int ACC_W     = 28,
   parameter int GATE_LOG2 = 22
) (
   input  logic             CLOCK_50,
   input  logic             reset,
   input  logic             sig_in,
   input  logic             start,
   output logic             busy,
   output logic [ACC_W-1:0] m_out,
   output logic             m_valid,
   input  logic             m_ack,
   output logic             no_signal
);

   localparam int SHIFT = ACC_W - GATE_LOG2;

   typedef enum logic [1:0] {IDLE, GATE, DONE} state_t;

   state_t               state, state_next;
   logic                 s1, s2, s3;
   logic                 rise;
   logic [GATE_LOG2-1:0] edge_cnt, gate_cnt;
   logic [GATE_LOG2-1:0] edges_next;
   logic                 gate_last;
   logic                 clear, finish, release_result;

   assign rise       = s2 & ~s3;
   assign gate_last  = (gate_cnt == '1);
   // Includes a rise on the final gate cycle so no edge straddles two windows.
   assign edges_next = edge_cnt + GATE_LOG2'(rise);
   assign busy       = (state == GATE);

   always_ff @(posedge CLOCK_50 or negedge reset) begin
      if (!reset) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
         s3 <= 1'b0;
      end else begin
         s1 <= sig_in;
         s2 <= s1;
         s3 <= s2;
      end
   end

   always_ff @(posedge CLOCK_50 or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next     = state;
      clear          = 1'b0;
      finish         = 1'b0;
      release_result = 1'b0;
      case (state)
         IDLE: begin
`ifdef FREQ_METER_CONT_EN
            state_next = GATE;
            clear      = 1'b1;
`else
            if (start) begin
               state_next = GATE;
               clear      = 1'b1;
            end
`endif
         end
         GATE: begin
            if (gate_last) begin
               finish = 1'b1;
`ifdef FREQ_METER_CONT_EN
               state_next = GATE;
`else
               state_next = DONE;
`endif
            end
         end
         DONE: begin
            if (start) begin
               state_next     = GATE;
               clear          = 1'b1;
               release_result = 1'b1;
            end else if (m_ack) begin
               state_next     = IDLE;
               release_result = 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge CLOCK_50 or negedge reset) begin
      if (!reset) begin
         edge_cnt <= '0;
         gate_cnt <= '0;
      end else if (clear) begin
         edge_cnt <= '0;
         gate_cnt <= '0;
      end else if (state == GATE) begin
         gate_cnt <= gate_cnt + GATE_LOG2'(1);
         edge_cnt <= finish ? '0 : edges_next;
      end
   end

   always_ff @(posedge CLOCK_50 or negedge reset) begin
      if (!reset) begin
         m_out     <= '0;
         no_signal <= 1'b0;
         m_valid   <= 1'b0;
      end else begin
         if (finish) begin
            m_out     <= ACC_W'(edges_next) << SHIFT;
            no_signal <= (edges_next == '0);
         end
`ifdef FREQ_METER_CONT_EN
         m_valid <= finish;
`else
         if (finish)              m_valid <= 1'b1;
         else if (release_result) m_valid <= 1'b0;
`endif
      end
   end

endmodule

// File: tb/tb_dds_freq_meter.sv
// Directed bench for dds_freq_meter with a 256-cycle gate (GATE_LOG2=8, shift 20).
module tb_dds_freq_meter;

   logic        CLOCK_50 = 1'b0;
   logic        reset    = 1'b0;
   logic        sig_in   = 1'b0;
   logic        start    = 1'b0;
   logic        m_ack    = 1'b0;
   logic        busy, m_valid, no_signal;
   logic [27:0] m_out;

   int tests = 0;
   int fails = 0;
   int sig_half = 0;   // half-period of sig_in in cycles; 0 holds it low
   int sig_cnt  = 0;

   dds_freq_meter #(.ACC_W(28), .GATE_LOG2(8)) dut (
      .CLOCK_50 (CLOCK_50),
      .reset    (reset),
      .sig_in   (sig_in),
      .start    (start),
      .busy     (busy),
      .m_out    (m_out),
      .m_valid  (m_valid),
      .m_ack    (m_ack),
      .no_signal(no_signal)
   );

   always #10 CLOCK_50 = ~CLOCK_50;

   always @(negedge CLOCK_50) begin
      if (sig_half == 0) begin
         sig_in  = 1'b0;
         sig_cnt = 0;
      end else begin
         sig_cnt++;
         if (sig_cnt >= sig_half) begin
            sig_cnt = 0;
            sig_in  = ~sig_in;
         end
      end
   end

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) @(negedge CLOCK_50);
   endtask

   task automatic test_reset();
      #1;
      tests++;
      if ({busy, m_valid, no_signal, m_out} !== 31'd0) begin
         fails++;
         $display("FAIL reset_outputs: got busy=%b valid=%b nosig=%b m_out=%h want all 0",
                  busy, m_valid, no_signal, m_out);
      end
      @(negedge CLOCK_50);
      reset = 1'b1;
      idle(3);
   endtask

`ifndef FREQ_METER_CONT_EN
   // Raises start for one cycle, returns cycles until m_valid is seen.
   task automatic measure(output int n, output logic busy_seen);
      start = 1'b1;
      n = 0;
      busy_seen = 1'b0;
      do begin
         @(negedge CLOCK_50);
         start = 1'b0;
         n++;
         if (n == 1) busy_seen = busy;
      end while (!m_valid && n < 400);
   endtask

   task automatic ack();
      m_ack = 1'b1;
      @(negedge CLOCK_50);
      m_ack = 1'b0;
   endtask

   task automatic test_period16();
      int n;
      logic b;
      sig_half = 8;
      idle(40);
      measure(n, b);
      tests++;
      if (n !== 257) begin fails++; $display("FAIL p16_latency: got %0d want 257", n); end
      tests++;
      if (b !== 1'b1) begin fails++; $display("FAIL p16_busy_gate: got %b want 1", b); end
      tests++;
      if (m_out !== 28'h1000000) begin fails++; $display("FAIL p16_m_out: got %h want 1000000", m_out); end
      tests++;
      if (no_signal !== 1'b0 || busy !== 1'b0) begin
         fails++; $display("FAIL p16_flags: got nosig=%b busy=%b want 0 0", no_signal, busy);
      end
      idle(5);
      tests++;
      if (m_valid !== 1'b1 || m_out !== 28'h1000000) begin
         fails++; $display("FAIL p16_hold: got valid=%b m_out=%h want 1 1000000", m_valid, m_out);
      end
      ack();
      tests++;
      if (m_valid !== 1'b0 || m_out !== 28'h1000000) begin
         fails++; $display("FAIL p16_ack: got valid=%b m_out=%h want 0 1000000", m_valid, m_out);
      end
   endtask

   task automatic test_nyquist();
      int n;
      logic b;
      sig_half = 1;
      idle(10);
      measure(n, b);
      tests++;
      if (m_out !== 28'h8000000 || n !== 257) begin
         fails++; $display("FAIL nyquist: got m_out=%h lat=%0d want 8000000 257", m_out, n);
      end
      ack();
   endtask

   task automatic test_no_signal();
      int n;
      logic b;
      sig_half = 0;
      idle(10);
      measure(n, b);
      tests++;
      if (m_out !== 28'h0 || no_signal !== 1'b1 || n !== 257) begin
         fails++; $display("FAIL no_signal: got m_out=%h nosig=%b lat=%0d want 0 1 257", m_out, no_signal, n);
      end
      ack();
   endtask

   task automatic test_reset_mid_gate();
      int n;
      logic b;
      logic seen;
      sig_half = 8;
      idle(20);
      start = 1'b1;
      @(negedge CLOCK_50);
      start = 1'b0;
      idle(99);
      reset = 1'b0;
      #1;
      tests++;
      if ({busy, m_valid, no_signal, m_out} !== 31'd0) begin
         fails++; $display("FAIL midgate_reset: got busy=%b valid=%b nosig=%b m_out=%h want all 0",
                           busy, m_valid, no_signal, m_out);
      end
      @(negedge CLOCK_50);
      reset = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 300; i++) begin
         @(negedge CLOCK_50);
         if (m_valid || busy) seen = 1'b1;
      end
      tests++;
      if (seen !== 1'b0) begin fails++; $display("FAIL midgate_no_result: got activity=%b want 0", seen); end
      measure(n, b);
      tests++;
      if (m_out !== 28'h1000000 || n !== 257) begin
         fails++; $display("FAIL after_reset: got m_out=%h lat=%0d want 1000000 257", m_out, n);
      end
   endtask

   // Entered with a valid result pending in DONE.
   task automatic test_back_to_back();
      int n;
      start = 1'b1;
      m_ack = 1'b1;
      @(negedge CLOCK_50);
      start = 1'b0;
      m_ack = 1'b0;
      n = 1;
      tests++;
      if (busy !== 1'b1 || m_valid !== 1'b0) begin
         fails++; $display("FAIL b2b_restart: got busy=%b valid=%b want 1 0", busy, m_valid);
      end
      while (!m_valid && n < 400) begin
         if (n == 50 || n == 120) start = 1'b1;
         @(negedge CLOCK_50);
         start = 1'b0;
         n++;
      end
      tests++;
      if (n !== 257 || m_out !== 28'h1000000) begin
         fails++; $display("FAIL b2b_window: got lat=%0d m_out=%h want 257 1000000", n, m_out);
      end
      ack();
   endtask
`else
   task automatic wait_pulse(output int n);
      n = 0;
      do begin
         @(negedge CLOCK_50);
         n++;
      end while (!m_valid && n < 600);
   endtask

   task automatic test_continuous();
      int n;
      wait_pulse(n);
      tests++;
      if (m_valid !== 1'b1 || busy !== 1'b1) begin
         fails++; $display("FAIL cont_first: got valid=%b busy=%b want 1 1", m_valid, busy);
      end
      for (int k = 0; k < 3; k++) begin
         if (k == 1) begin start = 1'b1; m_ack = 1'b1; end
         wait_pulse(n);
         start = 1'b0;
         m_ack = 1'b0;
         tests++;
         if (n !== 256 || m_out !== 28'h0800000) begin
            fails++; $display("FAIL cont_p32_%0d: got gap=%0d m_out=%h want 256 0800000", k, n, m_out);
         end
      end
      @(negedge CLOCK_50);
      tests++;
      if (m_valid !== 1'b0 || busy !== 1'b1) begin
         fails++; $display("FAIL cont_pulse_width: got valid=%b busy=%b want 0 1", m_valid, busy);
      end
      sig_half = 4;
      wait_pulse(n);
      wait_pulse(n);
      tests++;
      if (n !== 256 || m_out !== 28'h2000000) begin
         fails++; $display("FAIL cont_p8: got gap=%0d m_out=%h want 256 2000000", n, m_out);
      end
   endtask
`endif

   initial begin
`ifdef FREQ_METER_CONT_EN
      sig_half = 16;
`endif
      test_reset();
`ifdef FREQ_METER_CONT_EN
      test_continuous();
`else
      test_period16();
      test_nyquist();
      test_no_signal();
      test_reset_mid_gate();
      test_back_to_back();
`endif
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
